// File: rtl/slave_wr_data_fifo_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : slave_wr_data_fifo_drain                                         |
// | Purpose : Drains one AXI write burst from the write-data FIFO into a       |
// |           ready/valid memory write stream, checks WLAST, returns BRESP.    |
// | Option  : SLAVE_WR_DATA_FIFO_DRAIN_STRB_SKIP_EN - zero-strobe beats are     |
// |           consumed internally instead of being presented to memory.        |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module slave_wr_data_fifo_drain #(
    parameter int DATA_W = 32,
    parameter int STRB_W = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rstn,

    output logic                     fifo_rd_en,
    input  logic                     fifo_rd_empty,
    input  logic [DATA_W+STRB_W:0]   fifo_rd_data,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [LEN_W-1:0]         cmd_len,

    output logic                     mem_wr_en,
    input  logic                     mem_wr_ready,
    output logic [ADDR_W-1:0]        mem_wr_addr,
    output logic [DATA_W-1:0]        mem_wr_data,
    output logic [STRB_W-1:0]        mem_wr_strb,

    output logic                     b_valid,
    input  logic                     b_ready,
    output logic [1:0]               b_resp
);

    localparam int                c_BEAT_W    = DATA_W + STRB_W + 1;
    localparam int                c_CNT_W     = LEN_W + 1;
    localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(STRB_W);
    localparam logic [1:0]        c_RESP_OKAY = 2'b00;
    localparam logic [1:0]        c_RESP_SLV  = 2'b10;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_DATA = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]          state_q,    state_d;
    logic                init_q;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [LEN_W-1:0]    len_q,      len_d;
    logic [c_CNT_W-1:0]  issued_q,   issued_d;
    logic [c_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic                err_q,      err_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          occ_q,      occ_d;
    logic [c_BEAT_W-1:0] skid0_q,    skid0_d;
    logic [c_BEAT_W-1:0] skid1_q,    skid1_d;

    // ------------------------------------------------------------------
    // Combinational view of the beat queue
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0]  w_len_ext;
    logic [1:0]          w_total;
    logic                w_head_valid;
    logic [c_BEAT_W-1:0] w_head;
    logic [c_BEAT_W-1:0] w_second;
    logic                w_head_last;
    logic [STRB_W-1:0]   w_head_strb;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_skip;
    logic                w_in_data;
    logic                w_accept;
    logic                w_last_beat;
    logic                w_pop;
    logic                w_cmd_fire;

    assign w_len_ext    = {1'b0, len_q};
    assign w_in_data    = (state_q == c_S_DATA);
    assign w_total      = occ_q + {1'b0, inflight_q};
    assign w_head_valid = (w_total != 2'd0);

    // The beat returning from the FIFO is presented straight away when the
    // skid buffer is empty, which gives full throughput and the 2-cycle
    // command-to-first-write latency; it is captured into the skid buffer
    // on the same edge, so a stalled beat stays stable on the outputs.
    assign w_head   = (occ_q == 2'd0 && inflight_q) ? fifo_rd_data : skid0_q;
    assign w_second = (occ_q == 2'd2) ? skid1_q : fifo_rd_data;

    assign w_head_last = w_head[c_BEAT_W-1];
    assign w_head_strb = w_head[DATA_W +: STRB_W];
    assign w_head_data = w_head[DATA_W-1:0];

`ifdef SLAVE_WR_DATA_FIFO_DRAIN_STRB_SKIP_EN
    assign w_skip = (w_head_strb == '0);
`else
    assign w_skip = 1'b0;
`endif

    assign w_accept    = w_in_data && w_head_valid && (w_skip || mem_wr_ready);
    assign w_last_beat = (beat_cnt_q == w_len_ext);
    assign w_pop       = w_in_data && !fifo_rd_empty
                         && (issued_q <= w_len_ext)
                         && (w_total < 2'd2);
    assign w_cmd_fire  = cmd_valid && cmd_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= c_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            c_S_IDLE: begin
                if (w_cmd_fire) begin
                    state_d = c_S_DATA;
                end
            end
            c_S_DATA: begin
                if (w_accept && w_last_beat) begin
                    state_d = c_S_RESP;
                end
            end
            c_S_RESP: begin
                if (b_ready) begin
                    state_d = c_S_IDLE;
                end
            end
            default: begin
                state_d = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready   = 1'b0;
        b_valid     = 1'b0;
        b_resp      = c_RESP_OKAY;
        fifo_rd_en  = w_pop;
        mem_wr_en   = w_in_data && w_head_valid && !w_skip;
        mem_wr_addr = addr_q;
        mem_wr_data = w_head_data;
        mem_wr_strb = w_head_strb;
        unique case (state_q)
            c_S_IDLE: begin
                cmd_ready = init_q;
            end
            c_S_RESP: begin
                b_valid = 1'b1;
                b_resp  = err_q ? c_RESP_SLV : c_RESP_OKAY;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        inflight_d = w_pop;
        occ_d      = occ_q;
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;

        if (state_q == c_S_IDLE && w_cmd_fire) begin
            addr_d     = cmd_addr;
            len_d      = cmd_len;
            issued_d   = '0;
            beat_cnt_d = '0;
            err_d      = 1'b0;
        end

        if (w_pop) begin
            issued_d = issued_q + c_CNT_W'(1);
        end

        if (w_accept) begin
            addr_d     = addr_q + c_ADDR_STEP;
            beat_cnt_d = beat_cnt_q + c_CNT_W'(1);
            // WLAST must be set exactly on the beat selected by cmd_len.
            err_d      = err_q | (w_head_last != w_last_beat);
        end

        if (w_head_valid) begin
            if (w_accept) begin
                skid0_d = w_second;
                occ_d   = w_total - 2'd1;
            end else begin
                skid0_d = w_head;
                skid1_d = w_second;
                occ_d   = w_total;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            init_q     <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            skid0_q    <= '0;
            skid1_q    <= '0;
        end else begin
            init_q     <= 1'b1;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slave_wr_data_fifo_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_slave_wr_data_fifo_drain                                      |
// | Purpose : Directed, table-driven bench for slave_wr_data_fifo_drain with   |
// |           a 1-cycle-latency FIFO model and a negedge write monitor.        |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_slave_wr_data_fifo_drain;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 8;
    localparam int BEAT_W = DATA_W + STRB_W + 1;
`ifdef SLAVE_WR_DATA_FIFO_DRAIN_STRB_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              fifo_rd_en;
    logic              fifo_rd_empty;
    logic [BEAT_W-1:0] fifo_rd_data = '0;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              mem_wr_en;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [STRB_W-1:0] mem_wr_strb;
    logic              b_valid;
    logic              b_ready;
    logic [1:0]        b_resp;

    always #5 clk = ~clk;

    slave_wr_data_fifo_drain #(
        .DATA_W (DATA_W),
        .STRB_W (STRB_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_data  (fifo_rd_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_ready  (mem_wr_ready),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_strb   (mem_wr_strb),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_resp        (b_resp)
    );

    // FIFO model: 1-cycle read latency, never reset by the DUT
    logic [BEAT_W-1:0] fmem [0:63];
    int unsigned       wr_ptr = 0;
    int unsigned       rd_ptr = 0;
    int                n_underflow = 0;

    assign fifo_rd_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (wr_ptr == rd_ptr) n_underflow <= n_underflow + 1;
            fifo_rd_data <= fmem[rd_ptr % 64];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Write monitor, sampled mid-cycle
    int                ncyc = 0;
    int                nlog = 0;
    int                acc_cyc = 0;
    int                stall_viol = 0;
    logic [31:0]       log_addr [0:63];
    logic [31:0]       log_data [0:63];
    logic [3:0]        log_strb [0:63];
    int                log_cyc  [0:63];
    logic              prev_stall = 1'b0;
    logic [67:0]       prev_beat  = '0;

    always @(negedge clk) begin
        if (rstn) begin
            if (cmd_valid && cmd_ready) acc_cyc = ncyc;
            if (prev_stall && !(mem_wr_en && {mem_wr_addr, mem_wr_data, mem_wr_strb} == prev_beat))
                stall_viol = stall_viol + 1;
            prev_stall = mem_wr_en && !mem_wr_ready;
            prev_beat  = {mem_wr_addr, mem_wr_data, mem_wr_strb};
            if (mem_wr_en && mem_wr_ready && nlog < 64) begin
                log_addr[nlog] = mem_wr_addr;
                log_data[nlog] = mem_wr_data;
                log_strb[nlog] = mem_wr_strb;
                log_cyc[nlog]  = ncyc;
                nlog = nlog + 1;
            end
        end else begin
            prev_stall = 1'b0;
        end
        ncyc = ncyc + 1;
    end

    // Stimulus tables
    typedef struct {
        logic [BEAT_W-1:0] word;
        logic [31:0]       exp_addr;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        int          first;
        int          npre;
        bit          bp;
        logic [1:0]  exp_resp;
        bit          chk_time;
        int          left;
    } burst_t;

    beat_t  beats  [0:23];
    burst_t bursts [0:7];

    int       n_chk  = 0;
    int       n_fail = 0;
    int       cyc    = 0;
    bit       bp_mode = 1'b0;
    logic [3:0] bp_pat = 4'b1001;

    function automatic logic [BEAT_W-1:0] mk(input logic l, input logic [3:0] s, input logic [31:0] d);
        return {l, s, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (bp_mode) mem_wr_ready = bp_pat[cyc % 4];
    endtask

    task automatic push(input logic [BEAT_W-1:0] w);
        fmem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_bvalid(input string name);
        int t;
        t = 0;
        while (!b_valid && t < 300) begin
            tick();
            t++;
        end
        chk(name, 64'(b_valid), 64'd1);
    endtask

    // Holds the response for two cycles with a competing command, then releases it.
    task automatic finish_resp(input string name);
        cmd_valid = 1'b1;
        cmd_addr  = 32'hBAD0_0000;
        cmd_len   = 8'd0;
        b_ready   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk({name, "_cmd_ready_in_resp"}, 64'(cmd_ready), 64'd0);
            chk({name, "_b_valid_held"}, 64'(b_valid), 64'd1);
        end
        cmd_valid = 1'b0;
        b_ready   = 1'b1;
        tick();
        b_ready   = 1'b0;
        chk({name, "_b_valid_dropped"}, 64'(b_valid), 64'd0);
        chk({name, "_back_to_idle"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_burst(input int b);
        burst_t            bb;
        logic [BEAT_W-1:0] w;
        int                start_log;
        int unsigned       start_rd;
        int                k;
        int                t;
        string             nm;
        bb = bursts[b];
        nm = $sformatf("burst%0d", b);
        for (int i = 0; i < bb.npre; i++) push(beats[bb.first + i].word);
        bp_mode      = bb.bp;
        mem_wr_ready = bb.bp ? bp_pat[cyc % 4] : 1'b1;
        start_log    = nlog;
        start_rd     = rd_ptr;

        t = 0;
        while (!cmd_ready && t < 20) begin
            tick();
            t++;
        end
        chk({nm, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_addr  = bb.addr;
        cmd_len   = bb.len;
        tick();
        cmd_valid = 1'b0;

        wait_bvalid({nm, "_b_valid"});
        chk({nm, "_b_resp"}, 64'(b_resp), 64'(bb.exp_resp));
        chk({nm, "_pops"}, 64'(rd_ptr - start_rd), 64'(bb.len) + 64'd1);
        chk({nm, "_fifo_left"}, 64'(wr_ptr - rd_ptr), 64'(bb.left));

        k = 0;
        for (int i = 0; i <= int'(bb.len); i++) begin
            w = beats[bb.first + i].word;
            if (!(SKIP_EN && w[35:32] == 4'h0)) begin
                chk($sformatf("%s_addr%0d", nm, k), 64'(log_addr[(start_log + k) % 64]), 64'(beats[bb.first + i].exp_addr));
                chk($sformatf("%s_data%0d", nm, k), 64'(log_data[(start_log + k) % 64]), 64'(w[31:0]));
                chk($sformatf("%s_strb%0d", nm, k), 64'(log_strb[(start_log + k) % 64]), 64'(w[35:32]));
                if (bb.chk_time)
                    chk($sformatf("%s_cycle%0d", nm, k), 64'(log_cyc[(start_log + k) % 64]), 64'(acc_cyc + 2 + k));
                k++;
            end
        end
        chk({nm, "_write_count"}, 64'(nlog - start_log), 64'(k));
        bp_mode      = 1'b0;
        mem_wr_ready = 1'b1;
        finish_resp(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int start_log;

        beats[0]  = '{mk(1'b1, 4'hF, 32'hDEADBEEF), 32'h0000_0100};
        beats[1]  = '{mk(1'b0, 4'hF, 32'h1),        32'h0000_2000};
        beats[2]  = '{mk(1'b0, 4'hF, 32'h2),        32'h0000_2004};
        beats[3]  = '{mk(1'b0, 4'hF, 32'h3),        32'h0000_2008};
        beats[4]  = '{mk(1'b1, 4'hF, 32'h4),        32'h0000_200C};
        beats[5]  = '{mk(1'b0, 4'hF, 32'h1),        32'h0000_2000};
        beats[6]  = '{mk(1'b0, 4'hF, 32'h2),        32'h0000_2004};
        beats[7]  = '{mk(1'b0, 4'hF, 32'h3),        32'h0000_2008};
        beats[8]  = '{mk(1'b1, 4'hF, 32'h4),        32'h0000_200C};
        beats[9]  = '{mk(1'b1, 4'hF, 32'hA),        32'h0000_0300};
        beats[10] = '{mk(1'b0, 4'hF, 32'hB),        32'h0000_0304};
        beats[11] = '{mk(1'b0, 4'h3, 32'h11),       32'h0000_0400};
        beats[12] = '{mk(1'b1, 4'hC, 32'h12),       32'h0000_0404};
        beats[13] = '{mk(1'b0, 4'hF, 32'h21),       32'h0000_0500};
        beats[14] = '{mk(1'b0, 4'h1, 32'h22),       32'h0000_0504};
        beats[15] = '{mk(1'b0, 4'hF, 32'h23),       32'h0000_0508};
        beats[16] = '{mk(1'b1, 4'hF, 32'h24),       32'h0000_050C};
        beats[17] = '{mk(1'b0, 4'hF, 32'h31),       32'hFFFF_FFF8};
        beats[18] = '{mk(1'b0, 4'hF, 32'h32),       32'hFFFF_FFFC};
        beats[19] = '{mk(1'b0, 4'hF, 32'h33),       32'h0000_0000};
        beats[20] = '{mk(1'b1, 4'hF, 32'h34),       32'h0000_0004};
        beats[21] = '{mk(1'b0, 4'hF, 32'h41),       32'h0000_0000};
        beats[22] = '{mk(1'b0, 4'h0, 32'h42),       32'h0000_0004};
        beats[23] = '{mk(1'b1, 4'hF, 32'h43),       32'h0000_0008};

        //               addr          len  first npre bp    resp   time  left
        bursts[0] = '{32'h0000_0100, 8'd0,  0,   1, 1'b0, 2'b00, 1'b1, 0};
        bursts[1] = '{32'h0000_2000, 8'd3,  1,   4, 1'b0, 2'b00, 1'b1, 0};
        bursts[2] = '{32'h0000_2000, 8'd3,  5,   4, 1'b1, 2'b00, 1'b0, 0};
        bursts[3] = '{32'h0000_0300, 8'd1,  9,   2, 1'b0, 2'b10, 1'b1, 0};
        bursts[4] = '{32'h0000_0400, 8'd1, 11,   6, 1'b0, 2'b00, 1'b1, 4};
        bursts[5] = '{32'h0000_0500, 8'd3, 13,   0, 1'b0, 2'b00, 1'b1, 0};
        bursts[6] = '{32'hFFFF_FFF8, 8'd3, 17,   4, 1'b1, 2'b00, 1'b0, 0};
        bursts[7] = '{32'h0000_0000, 8'd2, 21,   3, 1'b0, 2'b00, 1'b0, 0};

        rstn         = 1'b0;
        cmd_valid    = 1'b0;
        cmd_addr     = '0;
        cmd_len      = '0;
        mem_wr_ready = 1'b1;
        b_ready      = 1'b0;

        tick();
        tick();
        chk("reset_cmd_ready",  64'(cmd_ready),   64'd0);
        chk("reset_fifo_rd_en", 64'(fifo_rd_en),  64'd0);
        chk("reset_mem_wr_en",  64'(mem_wr_en),   64'd0);
        chk("reset_mem_addr",   64'(mem_wr_addr), 64'd0);
        chk("reset_mem_data",   64'(mem_wr_data), 64'd0);
        chk("reset_b_valid",    64'(b_valid),     64'd0);
        chk("reset_b_resp",     64'(b_resp),      64'd0);
        rstn = 1'b1;
        tick();
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        for (int b = 0; b < 8; b++) run_burst(b);

        // FIFO runs dry mid-burst: output must pause, then resume
        start_log = nlog;
        push(mk(1'b0, 4'hF, 32'h51));
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0600;
        cmd_len   = 8'd2;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("dry_partial_writes", 64'(nlog - start_log), 64'd1);
        chk("dry_mem_wr_en_low",  64'(mem_wr_en),        64'd0);
        chk("dry_no_b_valid",     64'(b_valid),          64'd0);
        push(mk(1'b0, 4'hF, 32'h52));
        push(mk(1'b1, 4'hF, 32'h53));
        wait_bvalid("dry_b_valid");
        chk("dry_b_resp",      64'(b_resp),                        64'd0);
        chk("dry_write_count", 64'(nlog - start_log),              64'd3);
        chk("dry_last_addr",   64'(log_addr[(start_log + 2) % 64]), 64'h608);
        chk("dry_last_data",   64'(log_data[(start_log + 2) % 64]), 64'h53);
        finish_resp("dry");

        // Asynchronous reset while a beat is stalled on the memory port
        for (int i = 0; i < 4; i++) push(mk(i == 3, 4'hF, 32'h61 + 32'(i)));
        mem_wr_ready = 1'b0;
        cmd_valid    = 1'b1;
        cmd_addr     = 32'h0000_0700;
        cmd_len      = 8'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_reset_mem_wr_en", 64'(mem_wr_en),   64'd1);
        chk("pre_reset_mem_addr",  64'(mem_wr_addr), 64'h700);
        chk("pre_reset_mem_data",  64'(mem_wr_data), 64'h61);
        rstn = 1'b0;
        #1;
        chk("async_reset_mem_wr_en",  64'(mem_wr_en),   64'd0);
        chk("async_reset_mem_addr",   64'(mem_wr_addr), 64'd0);
        chk("async_reset_mem_data",   64'(mem_wr_data), 64'd0);
        chk("async_reset_mem_strb",   64'(mem_wr_strb), 64'd0);
        chk("async_reset_fifo_rd_en", 64'(fifo_rd_en),  64'd0);
        chk("async_reset_cmd_ready",  64'(cmd_ready),   64'd0);
        chk("async_reset_b_valid",    64'(b_valid),     64'd0);
        chk("async_reset_b_resp",     64'(b_resp),      64'd0);
        tick();
        rstn         = 1'b1;
        mem_wr_ready = 1'b1;
        tick();
        chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post_reset_mem_wr_en", 64'(mem_wr_en), 64'd0);

        chk("stall_stability", 64'(stall_viol),  64'd0);
        chk("fifo_underflow",  64'(n_underflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slave_wr_data_fifo_drain.md
Name: slave_wr_data_fifo_drain

Overview:
- Read-side consumer of the AXI4 slave write-data async FIFO, in the FIFO's read clock domain.
- Takes one write-burst command (start address, AXI len), pops exactly len+1 beats from the FIFO and turns them into a ready/valid memory write stream with incrementing addresses.
- Checks WLAST framing and returns one write response per burst.
- Sits between the FIFO read port and the slave's memory/register write interface.

Parameters:
- DATA_W, 32, write data width; must match the FIFO read data minus strobe and last bits.
- STRB_W, 4, byte strobe width, DATA_W/8.
- ADDR_W, 32, byte address width.
- LEN_W, 8, AXI burst length field width.

Ports:
- clk  in  1  FIFO read clock, sole clock.
- rstn  in  1  asynchronous active-low reset.
- fifo_rd_en  out  1  FIFO pop; equivalent to FIFO rd_en / rd_clk_en.
- fifo_rd_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  DATA_W+STRB_W+1  packed {wlast, wstrb, wdata}; valid one cycle after fifo_rd_en.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  burst command accept.
- cmd_addr  in  ADDR_W  burst start byte address, aligned to STRB_W.
- cmd_len  in  LEN_W  beats minus one.
- mem_wr_en  out  1  memory write valid.
- mem_wr_ready  in  1  memory write accept.
- mem_wr_addr  out  ADDR_W  beat byte address.
- mem_wr_data  out  DATA_W  beat data.
- mem_wr_strb  out  STRB_W  beat byte enables.
- b_valid  out  1  write response valid.
- b_ready  in  1  write response accept.
- b_resp  out  2  2'b00 OKAY, 2'b10 SLVERR.

Behaviour:
- Reset: rstn low asynchronously clears all state. Outputs go to fifo_rd_en=0, cmd_ready=0, mem_wr_en=0, mem_wr_addr/data/strb=0, b_valid=0, b_resp=0. The FSM returns to IDLE, and the skid buffer and counters clear.
- Reset mid-burst discards in-flight beats. Resetting the FIFO is the integrator's job.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr and len, clear the err flag and the issue/beat counters, then go to DATA. cmd_ready is low in all other states.
  - DATA: prefetch and issue beats (rules below). When the beat with beat_cnt==len is accepted, go to RESP.
  - RESP: b_valid=1, b_resp = err ? 2'b10 : 2'b00. On b_ready, go to IDLE next cycle.
- Prefetch:
  - The FIFO has 1-cycle read latency, so a 2-entry skid buffer holds returned beats.
  - fifo_rd_en = DATA && !fifo_rd_empty && (issued <= len) && (occupancy + inflight < 2).
  - issued counts pops in this burst and must never exceed len+1. The FIFO is never popped outside DATA, so the next burst's beats stay in the FIFO.
- Output:
  - mem_wr_en is high whenever the skid head is valid.
  - addr/data/strb are held stable while mem_wr_en && !mem_wr_ready.
  - A beat is accepted on mem_wr_en && mem_wr_ready.
- Address: starts at cmd_addr and increments by STRB_W per accepted beat, modulo 2^ADDR_W (INCR only; wrap at 2^ADDR_W is silent).
- Throughput: 1 beat/cycle sustained when the FIFO is non-empty and mem_wr_ready=1. The first mem_wr_en is 2 cycles after the command is accepted (pop in the first DATA cycle, data the cycle after).
- Framing check (sets sticky err):
  - wlast=1 on any beat with beat_cnt<len.
  - wlast=0 on the beat with beat_cnt==len.
  - Mismatched beats are still written. The beat count is governed by cmd_len, not wlast.
- Simultaneous events:
  - A pop return and an acceptance in the same cycle keep occupancy constant.
  - In RESP, cmd_valid is ignored until IDLE.
- FIFO empty mid-burst: mem_wr_en drops once the skid buffer drains and resumes when data arrives; there is no timeout.

Optional Feature:
- Macro: SLAVE_WR_DATA_FIFO_DRAIN_STRB_SKIP_EN.
- Defined: a beat with wstrb==0 is consumed internally without asserting mem_wr_en. Its address still advances, beat_cnt still increments, and it takes one cycle and needs no mem_wr_ready.
- Undefined: all beats are presented on mem_wr_en, including zero-strobe beats.

Test Plan:
- Single beat: cmd addr=0x100, len=0; FIFO holds {1,0xF,0xDEADBEEF}. Required: one mem write addr=0x100 data=0xDEADBEEF strb=0xF, then b_resp=00, FIFO empty, back to IDLE.
- 4-beat burst with mem_wr_ready=1: addr=0x2000, len=3, data 1..4 with last on beat 4. Required: mem addrs 0x2000/04/08/0C on 4 consecutive cycles, b_resp=00.
- Backpressure: same burst with mem_wr_ready toggling 1,0,0,1,…. Required: no beat lost or duplicated, outputs stable while stalled, never more than 4 pops.
- Framing error: len=1, beat 1 has wlast=1 and beat 2 has wlast=0. Required: both beats written, b_resp=10.
- Back-to-back bursts with the FIFO preloaded with 6 beats (len=1, then len=3): first b_valid after 2 pops, second burst reads the remaining 4. Also assert rstn low mid-burst: outputs zero immediately, cmd_ready=1 after release.
- With SLAVE_WR_DATA_FIFO_DRAIN_STRB_SKIP_EN defined: len=2, beat 2 has strb=0. Required: writes at 0x0 and 0x8 only, b_resp=00.
